sisc_ctrl_mc: RTL
=================

SISC_CTRL_MC -- requirements
Module: sisc_ctrl_mc

Interface
REQ-001 SHALL have parameter OPW, default 4, opcode field width.
REQ-002 SHALL have parameter MMW, default 4, mode/condition field width; status input is also MMW bits wide.
REQ-003 SHALL have parameter CNTW, default 16, retired-instruction counter width.
REQ-004 SHALL have parameter MEM_TIMEOUT, default 8, maximum number of wait cycles per memory handshake.
REQ-005 SHALL have ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- opcode  in  OPW  instruction opcode.
- mm  in  MMW  mode/condition field.
- stat  in  MMW  status register value.
- mem_ready  in  1  memory acknowledge.
- rf_we  out  1  register-file write enable.
- alu_op  out  2  bit 1: do not save status; bit 0: use immediate.
- wb_sel  out  1  writeback source: 0 = ALU result, 1 = memory data.
- br_sel  out  1  1 = absolute branch target, 0 = relative.
- rb_sel  out  1  selects the RB address mux.
- ir_load  out  1  instruction-register load.
- pc_sel  out  1  1 = branch target, 0 = PC+1.
- pc_write  out  1  PC write enable.
- pc_rst  out  1  PC reset.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write.
- halted  out  1  halt flag.
- mem_err  out  1  memory-timeout flag, sticky.
- instr_count  out  CNTW  retired-instruction count.

Function
REQ-006 SHALL implement the states START, FETCH, DECODE, EXECUTE, MEM, WB, WB2 and HALT, held in a registered state variable.
REQ-007 SHALL transition START->FETCH unconditionally.
REQ-008 SHALL hold FETCH, with mem_req=1, until mem_ready=1; in that cycle it SHALL assert ir_load=1, pc_write=1 and pc_sel=0, then go to DECODE.
REQ-009 SHALL go from DECODE to HALT if opcode=15, otherwise to EXECUTE.
REQ-010 In DECODE it SHALL drive br_sel=1 for BRA(4) and BNE(6), and 0 otherwise.
REQ-011 SHALL compute cond = |(mm & stat).
REQ-012 BRA/BRR SHALL be taken when mm=0 or cond=1; BNE/BNR SHALL be taken when mm!=0 and cond=0.
REQ-013 In EXECUTE, a taken branch SHALL assert pc_sel=1 and pc_write=1; a not-taken branch SHALL leave the PC unwritten.
REQ-014 Branch instructions and NOOP(0) SHALL go from EXECUTE to FETCH.
REQ-015 For ALU_OP(8), EXECUTE SHALL drive alu_op=2'b01 when mm=8 and 2'b00 otherwise, then go to WB.
REQ-016 For LOD(1), STR(2) and SWP(3), EXECUTE SHALL drive alu_op=2'b11 and go to MEM.
REQ-017 MEM SHALL hold mem_req=1, and mem_we=1 for STR, until mem_ready=1.
REQ-018 On mem_ready in MEM, STR SHALL go to FETCH; LOD and SWP SHALL go to WB.
REQ-019 For ALU_OP, WB SHALL assert rf_we=1 with wb_sel=0 and alu_op=2'b00 or 2'b01 per REQ-015, so the status register is saved; for LOD and SWP, WB SHALL assert rf_we=1 with wb_sel=1 and alu_op=2'b10.
REQ-020 SWP SHALL proceed WB->WB2; WB2 SHALL assert rf_we=1, rb_sel=1 and wb_sel=0, then go to FETCH.
REQ-021 All other opcodes SHALL go from WB to FETCH.
REQ-022 In every state other than those listed in REQ-008 to REQ-020, outputs SHALL default to rf_we=0, alu_op=2'b10, wb_sel=0, br_sel=0, rb_sel=0, ir_load=0, pc_sel=0, pc_write=0, mem_req=0 and mem_we=0.
REQ-023 A wait counter SHALL clear on entry to FETCH or MEM and increment each cycle mem_ready=0.
REQ-024 If the wait counter reaches MEM_TIMEOUT, the block SHALL set mem_err=1 and enter HALT.
REQ-025 mem_ready arriving in the same cycle as the timeout SHALL win: the handshake completes and mem_err is not set.
REQ-026 instr_count SHALL increment by 1, wrapping modulo 2^CNTW, on every transition into FETCH from EXECUTE, MEM, WB or WB2.
REQ-027 HALT SHALL be absorbing and hold halted=1, with all enables 0; only rst exits HALT.
REQ-028 mm and stat SHALL be sampled combinationally in EXECUTE; stat changes outside EXECUTE SHALL have no effect.

Reset
REQ-029 While rst=1, the state SHALL be START, pc_rst=1, instr_count=0, mem_err=0, halted=0, the wait counter=0, and all other outputs at the REQ-022 defaults.
REQ-030 Asserting rst mid-handshake SHALL immediately drop mem_req and mem_we with no further register or PC write.
REQ-031 The first FETCH SHALL occur on the second rising clk after rst deasserts.

Structure
REQ-032 The opcode constants (NOOP..HLT), the state encoding and the alu_op encodings SHALL live in a shared package, sisc_pkg.
REQ-033 The branch-condition evaluation (REQ-011/REQ-012) SHALL be a sub-module, br_cond, with inputs opcode, mm and stat and output taken.
REQ-034 The block SHALL contain no $stop or $display; halting SHALL be signalled only through halted.

Verification
REQ-035 Reset: rst pulse, then an ADD (opcode 8, mm=0) with mem_ready tied 1 -> pc_rst=1 during reset; FETCH,DECODE,EXECUTE,WB in 4 cycles; rf_we=1 only in WB; instr_count=1.
REQ-036 BNE: opcode 6, mm=4'b0001, with stat=4'b0001 and then stat=4'b0000 -> pc_write=0 in EXECUTE for the first and pc_write=1, pc_sel=1, br_sel=1 for the second.
REQ-037 LOD: mem_ready low for 3 cycles in MEM -> mem_req held 4 cycles, then WB with rf_we=1 and wb_sel=1; mem_err=0.
REQ-038 Timeout: MEM_TIMEOUT=8, mem_ready stuck 0 in FETCH -> mem_err=1 and halted=1 after 8 wait cycles; the state stays in HALT for 20 more cycles.
REQ-039 SWP: opcode 3 -> MEM, WB, WB2 each with rf_we=1 in WB and WB2; rb_sel=1 only in WB2; instr_count+1.
REQ-040 Wrap and halt: CNTW=2 with 5 NOOPs then HLT -> instr_count reads 1, halted=1, and no pc_write after HLT decode.

Source files
------------

// File: rtl/sisc_pkg.sv
// rtl/sisc_pkg.sv - shared opcode, state and alu_op encodings for the SISC multicycle controller
package sisc_pkg;

    localparam logic [3:0] OP_NOOP = 4'd0;
    localparam logic [3:0] OP_LOD  = 4'd1;
    localparam logic [3:0] OP_STR  = 4'd2;
    localparam logic [3:0] OP_SWP  = 4'd3;
    localparam logic [3:0] OP_BRA  = 4'd4;
    localparam logic [3:0] OP_BRR  = 4'd5;
    localparam logic [3:0] OP_BNE  = 4'd6;
    localparam logic [3:0] OP_BNR  = 4'd7;
    localparam logic [3:0] OP_ALU  = 4'd8;
    localparam logic [3:0] OP_HLT  = 4'd15;

    // alu_op bit 1 suppresses the status save, bit 0 selects the immediate operand
    localparam logic [1:0] ALU_SAVE     = 2'b00;
    localparam logic [1:0] ALU_SAVE_IMM = 2'b01;
    localparam logic [1:0] ALU_NOSAVE   = 2'b10;
    localparam logic [1:0] ALU_ADDR     = 2'b11;

    localparam int MODE_IMM = 8;

    typedef enum logic [2:0] {
        ST_START   = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_MEM     = 3'd4,
        ST_WB      = 3'd5,
        ST_WB2     = 3'd6,
        ST_HALT    = 3'd7
    } state_t;

endpackage

// File: rtl/br_cond.sv
// rtl/br_cond.sv - branch-taken evaluation from opcode, mode mask and status
module br_cond
    import sisc_pkg::*;
#(
    parameter int OPW = 4,
    parameter int MMW = 4
) (
    input  logic [OPW-1:0] opcode,
    input  logic [MMW-1:0] mm,
    input  logic [MMW-1:0] stat,
    output logic           taken
);

    logic cond;
    logic is_pos;
    logic is_neg;
    logic mm_zero;

    assign cond    = |(mm & stat);
    assign mm_zero = (mm == '0);
    assign is_pos  = (opcode == OPW'(OP_BRA)) || (opcode == OPW'(OP_BRR));
    assign is_neg  = (opcode == OPW'(OP_BNE)) || (opcode == OPW'(OP_BNR));

    // mm=0 means "always" for the positive forms and "never" for the negated ones
    assign taken = (is_pos && (mm_zero || cond)) || (is_neg && !mm_zero && !cond);

endmodule

// File: rtl/sisc_ctrl_mc.sv
// rtl/sisc_ctrl_mc.sv - multicycle SISC control unit with memory-handshake timeout and retire counter
module sisc_ctrl_mc
    import sisc_pkg::*;
#(
    parameter int OPW         = 4,
    parameter int MMW         = 4,
    parameter int CNTW        = 16,
    parameter int MEM_TIMEOUT = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OPW-1:0]  opcode,
    input  logic [MMW-1:0]  mm,
    input  logic [MMW-1:0]  stat,
    input  logic            mem_ready,
    output logic            rf_we,
    output logic [1:0]      alu_op,
    output logic            wb_sel,
    output logic            br_sel,
    output logic            rb_sel,
    output logic            ir_load,
    output logic            pc_sel,
    output logic            pc_write,
    output logic            pc_rst,
    output logic            mem_req,
    output logic            mem_we,
    output logic            halted,
    output logic            mem_err,
    output logic [CNTW-1:0] instr_count
);

    localparam int WCW = $clog2(MEM_TIMEOUT + 1);

    state_t         state;
    logic [WCW-1:0] wait_cnt;
    logic           taken;
    logic           timed_out;
    logic           is_br;
    logic           is_abs;
    logic           is_mem;
    logic           is_alu;
    logic           is_lod;
    logic           is_str;
    logic           is_swp;
    logic           is_hlt;
    logic           imm_mode;

    br_cond #(
        .OPW (OPW),
        .MMW (MMW)
    ) u_br_cond (
        .opcode (opcode),
        .mm     (mm),
        .stat   (stat),
        .taken  (taken)
    );

    assign is_lod   = (opcode == OPW'(OP_LOD));
    assign is_str   = (opcode == OPW'(OP_STR));
    assign is_swp   = (opcode == OPW'(OP_SWP));
    assign is_alu   = (opcode == OPW'(OP_ALU));
    assign is_hlt   = (opcode == OPW'(OP_HLT));
    assign is_mem   = is_lod || is_str || is_swp;
    assign is_abs   = (opcode == OPW'(OP_BRA)) || (opcode == OPW'(OP_BNE));
    assign is_br    = is_abs || (opcode == OPW'(OP_BRR)) || (opcode == OPW'(OP_BNR));
    assign imm_mode = (mm == MMW'(MODE_IMM));

    // The timeout is judged once the counter already holds MEM_TIMEOUT, so a late
    // mem_ready in that same cycle still completes the handshake.
    assign timed_out = (wait_cnt == WCW'(MEM_TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_START;
            wait_cnt    <= '0;
            instr_count <= '0;
            mem_err     <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (state)
                ST_START: begin
                    state    <= ST_FETCH;
                    wait_cnt <= '0;
                end
                ST_FETCH: begin
                    if (mem_ready) begin
                        state <= ST_DECODE;
                    end else if (timed_out) begin
                        state   <= ST_HALT;
                        mem_err <= 1'b1;
                        halted  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WCW'(1);
                    end
                end
                ST_DECODE: begin
                    if (is_hlt) begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                    end else begin
                        state <= ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    if (is_mem) begin
                        state    <= ST_MEM;
                        wait_cnt <= '0;
                    end else if (is_alu) begin
                        state <= ST_WB;
                    end else begin
                        state       <= ST_FETCH;
                        wait_cnt    <= '0;
                        instr_count <= instr_count + CNTW'(1);
                    end
                end
                ST_MEM: begin
                    if (mem_ready) begin
                        if (is_str) begin
                            state       <= ST_FETCH;
                            wait_cnt    <= '0;
                            instr_count <= instr_count + CNTW'(1);
                        end else begin
                            state <= ST_WB;
                        end
                    end else if (timed_out) begin
                        state   <= ST_HALT;
                        mem_err <= 1'b1;
                        halted  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WCW'(1);
                    end
                end
                ST_WB: begin
                    if (is_swp) begin
                        state <= ST_WB2;
                    end else begin
                        state       <= ST_FETCH;
                        wait_cnt    <= '0;
                        instr_count <= instr_count + CNTW'(1);
                    end
                end
                ST_WB2: begin
                    state       <= ST_FETCH;
                    wait_cnt    <= '0;
                    instr_count <= instr_count + CNTW'(1);
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state  <= ST_HALT;
                    halted <= 1'b1;
                end
            endcase
        end
    end

    // Datapath controls follow the current state and live inputs so handshakes act in the same cycle
    always_comb begin
        rf_we    = 1'b0;
        alu_op   = ALU_NOSAVE;
        wb_sel   = 1'b0;
        br_sel   = 1'b0;
        rb_sel   = 1'b0;
        ir_load  = 1'b0;
        pc_sel   = 1'b0;
        pc_write = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        case (state)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_load  = 1'b1;
                    pc_write = 1'b1;
                end
            end
            ST_DECODE: begin
                br_sel = is_abs;
            end
            ST_EXECUTE: begin
                if (is_br) begin
                    br_sel   = is_abs;
                    pc_sel   = taken;
                    pc_write = taken;
                end else if (is_alu) begin
                    alu_op = imm_mode ? ALU_SAVE_IMM : ALU_SAVE;
                end else if (is_mem) begin
                    alu_op = ALU_ADDR;
                end
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = is_str;
            end
            ST_WB: begin
                if (is_alu) begin
                    rf_we  = 1'b1;
                    alu_op = imm_mode ? ALU_SAVE_IMM : ALU_SAVE;
                end else if (is_lod || is_swp) begin
                    rf_we  = 1'b1;
                    wb_sel = 1'b1;
                end
            end
            ST_WB2: begin
                rf_we  = 1'b1;
                rb_sel = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign pc_rst = (state == ST_START);

endmodule
